// File: rtl/ahb_cmd_master_pkg.sv
// AHB-Lite encodings, address-phase payload and size/alignment helpers
// shared by the command master and its testbench.
package ahb_defs;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned SIZE_W = 3;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_NONSEQ = 2'b10
    } htrans_e;

    localparam logic [SIZE_W-1:0] HSIZE_BYTE    = 3'b000;
    localparam logic [SIZE_W-1:0] HSIZE_HALF    = 3'b001;
    localparam logic [SIZE_W-1:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0]        HBURST_SINGLE = 3'b000;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              write;
        logic [SIZE_W-1:0] size;
    } ahb_aphase_t;

    // Anything wider than a word is issued as a word transfer.
    function automatic logic [SIZE_W-1:0] norm_size(input logic [SIZE_W-1:0] size);
        return (size >= 3'b011) ? HSIZE_WORD : size;
    endfunction

    // Expects an already normalised size.
    function automatic logic [ADDR_W-1:0] align_addr(input logic [ADDR_W-1:0] addr,
                                                     input logic [SIZE_W-1:0] size);
        logic [ADDR_W-1:0] a;
        a = addr;
        case (size)
            HSIZE_HALF: a[0]   = 1'b0;
            HSIZE_WORD: a[1:0] = 2'b00;
            default:    a      = addr;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/ahb_cmd_master_wait_timer.sv
// Data-phase wait-state counter: saturates at WAIT_LIMIT and raises a
// sticky timeout flag when the limit is reached.
module ahb_wait_timer #(
    parameter int unsigned WAIT_LIMIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic stall_i,
    input  logic ready_i,
    output logic bus_timeout_o
);

    localparam int unsigned CNT_W = $clog2(WAIT_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WAIT_LIMIT);

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             timeout_q, timeout_d;

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        if (ready_i) begin
            wait_cnt_d = '0;
        end else if (stall_i && (wait_cnt_q != LIMIT)) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
        // Flag rises on the same edge the count reaches the limit.
        if (wait_cnt_d == LIMIT) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign bus_timeout_o = timeout_q;

endmodule

// File: rtl/ahb_cmd_master.sv
// AHB-Lite single-transfer master: valid/ready commands become pipelined
// NONSEQ transfers, each returning one response pulse.
module ahb_cmd_master
    import ahb_defs::*;
#(
    parameter logic [3:0]  HPROT_VAL  = 4'b0011,
    parameter int unsigned WAIT_LIMIT = 16
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [SIZE_W-1:0] cmd_size,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              bus_timeout,
    output logic [ADDR_W-1:0] HADDR,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic [SIZE_W-1:0] HSIZE,
    output logic [2:0]        HBURST,
    output logic [3:0]        HPROT,
    output logic [DATA_W-1:0] HWDATA,
    input  logic [DATA_W-1:0] HRDATA,
    input  logic              HREADY
);

    ahb_aphase_t       aph_q, aph_d;
    htrans_e           htrans_q, htrans_d;
    logic [DATA_W-1:0] wd_hold_q, wd_hold_d;
    logic              dp_valid_q, dp_valid_d;
    logic              dp_write_q, dp_write_d;
    logic [DATA_W-1:0] hwdata_q, hwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_write_q, rsp_write_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    // All pipeline stages advance together, only on edges with HREADY high.
    always_comb begin
        aph_d       = aph_q;
        htrans_d    = htrans_q;
        wd_hold_d   = wd_hold_q;
        dp_valid_d  = dp_valid_q;
        dp_write_d  = dp_write_q;
        hwdata_d    = hwdata_q;
        rsp_valid_d = 1'b0;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        if (HREADY) begin
            if (cmd_valid) begin
                aph_d.size  = norm_size(cmd_size);
                aph_d.addr  = align_addr(cmd_addr, aph_d.size);
                aph_d.write = cmd_write;
                htrans_d    = HTRANS_NONSEQ;
                wd_hold_d   = cmd_wdata;
            end else begin
                htrans_d    = HTRANS_IDLE;
            end
            if (htrans_q == HTRANS_NONSEQ) begin
                dp_valid_d = 1'b1;
                dp_write_d = aph_q.write;
                hwdata_d   = wd_hold_q;
            end else begin
                dp_valid_d = 1'b0;
            end
            if (dp_valid_q) begin
                rsp_valid_d = 1'b1;
                rsp_write_d = dp_write_q;
                rsp_rdata_d = dp_write_q ? '0 : HRDATA;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            aph_q       <= '0;
            htrans_q    <= HTRANS_IDLE;
            wd_hold_q   <= '0;
            dp_valid_q  <= 1'b0;
            dp_write_q  <= 1'b0;
            hwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            aph_q       <= aph_d;
            htrans_q    <= htrans_d;
            wd_hold_q   <= wd_hold_d;
            dp_valid_q  <= dp_valid_d;
            dp_write_q  <= dp_write_d;
            hwdata_q    <= hwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    ahb_wait_timer #(
        .WAIT_LIMIT (WAIT_LIMIT)
    ) u_wait_timer (
        .clk           (HCLK),
        .rst_n         (HRESETn),
        .stall_i       (dp_valid_q & ~HREADY),
        .ready_i       (HREADY),
        .bus_timeout_o (bus_timeout)
    );

    assign cmd_ready = HREADY;
    assign HADDR     = aph_q.addr;
    assign HWRITE    = aph_q.write;
    assign HSIZE     = aph_q.size;
    assign HTRANS    = htrans_q;
    assign HBURST    = HBURST_SINGLE;
    assign HPROT     = HPROT_VAL;
    assign HWDATA    = hwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_write = rsp_write_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_ahb_cmd_master.sv
// Directed bench for ahb_cmd_master against a 16-bit-register GPIO-style
// slave with programmable wait states; responses checked via a scoreboard.
module tb_ahb_cmd_master;

    logic        HCLK;
    logic        HRESETn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [2:0]  cmd_size;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_write;
    logic [31:0] rsp_rdata;
    logic        bus_timeout;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [1:0]  HTRANS;
    logic        HWRITE, HREADY;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;

    ahb_cmd_master #(.HPROT_VAL(4'b0011), .WAIT_LIMIT(16)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_size(cmd_size), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
        .bus_timeout(bus_timeout),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA), .HRDATA(HRDATA),
        .HREADY(HREADY)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Lane merge into a 16-bit register (only byte lanes 0 and 1 exist).
    function automatic logic [15:0] wmerge(input logic [15:0] old, input logic [1:0] a,
                                           input logic [2:0] sz, input logic [31:0] wd);
        logic [15:0] r;
        r = old;
        if (sz == 3'b000) begin
            if (a == 2'd0) r[7:0]  = wd[7:0];
            if (a == 2'd1) r[15:8] = wd[15:8];
        end else if (sz == 3'b001) begin
            if (a[1] == 1'b0) r = wd[15:0];
        end else begin
            r = wd[15:0];
        end
        return r;
    endfunction

    // Slave model
    logic [15:0] regs [16];
    int          wait_cfg;
    logic        s_act, s_wr;
    logic [31:0] s_addr;
    logic [2:0]  s_size;
    int          s_wait;

    assign HREADY = !(s_act && (s_wait != 0));
    assign HRDATA = {16'h0000, regs[s_addr[5:2]]};

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            s_act  <= 1'b0;
            s_wr   <= 1'b0;
            s_addr <= '0;
            s_size <= '0;
            s_wait <= 0;
        end else if (HREADY) begin
            if (s_act && s_wr)
                regs[s_addr[5:2]] <= wmerge(regs[s_addr[5:2]], s_addr[1:0], s_size, HWDATA);
            s_act  <= (HTRANS == 2'b10);
            s_addr <= HADDR;
            s_wr   <= HWRITE;
            s_size <= HSIZE;
            s_wait <= wait_cfg;
        end else begin
            s_wait <= s_wait - 1;
        end
    end

    // Scoreboard
    typedef struct { logic write; logic [31:0] rdata; } exp_t;
    exp_t        sb [$];
    logic [15:0] exp_mem [16];

    always @(negedge HCLK) begin
        if (HRESETn && rsp_valid) begin
            exp_t e;
            n_checks++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL rsp_unexpected observed=rsp_valid=1 expected=no response");
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("rsp_write", 32'(rsp_write), 32'(e.write));
                chk("rsp_rdata", rsp_rdata, e.rdata);
            end
        end
    end

    task automatic issue(input logic wr, input logic [2:0] sz,
                         input logic [31:0] a, input logic [31:0] wd);
        logic  r;
        logic [2:0] nsz;
        exp_t  e;
        @(negedge HCLK);
        cmd_valid = 1'b1; cmd_write = wr; cmd_size = sz; cmd_addr = a; cmd_wdata = wd;
        r = 1'b0;
        for (int n = 0; n < 50 && !r; n++) begin
            #4;
            r = cmd_ready;
            @(posedge HCLK);
            if (!r) @(negedge HCLK);
        end
        if (!r) begin
            chk("accept_timeout", 32'(r), 32'd1);
        end else begin
            nsz = (sz >= 3'b011) ? 3'b010 : sz;
            if (wr) begin
                exp_mem[a[5:2]] = wmerge(exp_mem[a[5:2]], a[1:0], nsz, wd);
                e.write = 1'b1; e.rdata = 32'h0;
            end else begin
                e.write = 1'b0; e.rdata = {16'h0000, exp_mem[a[5:2]]};
            end
            sb.push_back(e);
        end
    endtask

    task automatic idle();
        @(negedge HCLK);
        cmd_valid = 1'b0;
    endtask

    initial begin
        int stall;
        bit seen;
        for (int i = 0; i < 16; i++) begin regs[i] = 16'h0; exp_mem[i] = 16'h0; end
        HRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_size = 3'b0;
        cmd_addr = '0; cmd_wdata = '0; wait_cfg = 0;
        repeat (3) @(negedge HCLK);
        chk("rst_htrans", 32'(HTRANS), 32'd0);
        chk("rst_haddr", HADDR, 32'd0);
        chk("rst_hwrite", 32'(HWRITE), 32'd0);
        chk("rst_hsize", 32'(HSIZE), 32'd0);
        chk("rst_hwdata", HWDATA, 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_timeout", 32'(bus_timeout), 32'd0);
        chk("hburst", 32'(HBURST), 32'd0);
        chk("hprot", 32'(HPROT), 32'h3);
        HRESETn = 1'b1;

        // 1: single word write
        issue(1'b1, 3'b010, 32'h0, 32'h1a2b3c4d);
        #1;
        chk("t1_htrans", 32'(HTRANS), 32'h2);
        chk("t1_haddr", HADDR, 32'h0);
        chk("t1_hwrite", 32'(HWRITE), 32'd1);
        chk("t1_hsize", 32'(HSIZE), 32'h2);
        idle();
        @(posedge HCLK); #1;
        chk("t1_htrans_idle", 32'(HTRANS), 32'd0);
        chk("t1_hwdata", HWDATA, 32'h1a2b3c4d);
        @(posedge HCLK); #1;
        chk("t1_rsp_valid", 32'(rsp_valid), 32'd1);
        repeat (2) @(negedge HCLK);
        chk("t1_gpio_out0", 32'(regs[0]), 32'h3c4d);

        // 2: back-to-back write then read of the same word
        issue(1'b1, 3'b010, 32'h4, 32'h12345678);
        issue(1'b0, 3'b010, 32'h4, 32'h0);
        #1;
        chk("t2_read_aphase", 32'(HWRITE), 32'd0);
        chk("t2_overlap_hwdata", HWDATA, 32'h12345678);
        idle();
        repeat (3) @(negedge HCLK);

        // 3: byte write into lane 1, read back whole word
        issue(1'b1, 3'b000, 32'h1, 32'h00005500);
        #1;
        chk("t3_hsize", 32'(HSIZE), 32'h0);
        chk("t3_haddr", HADDR, 32'h1);
        issue(1'b0, 3'b010, 32'h0, 32'h0);
        idle();
        repeat (3) @(negedge HCLK);

        // Alignment and oversize normalisation
        issue(1'b1, 3'b001, 32'h9, 32'h0000beef);
        #1;
        chk("al_half_haddr", HADDR, 32'h8);
        chk("al_half_hsize", 32'(HSIZE), 32'h1);
        issue(1'b1, 3'b111, 32'hB, 32'h0000cafe);
        #1;
        chk("al_big_haddr", HADDR, 32'h8);
        chk("al_big_hsize", 32'(HSIZE), 32'h2);
        issue(1'b0, 3'b010, 32'h8, 32'h0);
        idle();
        repeat (3) @(negedge HCLK);

        // 4: three wait states on a read with a write queued behind it
        wait_cfg = 3;
        issue(1'b0, 3'b010, 32'h4, 32'h0);
        issue(1'b1, 3'b010, 32'h8, 32'h00001111);
        idle();
        wait_cfg = 0;
        stall = 0;
        for (int n = 0; n < 10; n++) begin
            if (cmd_ready) break;
            stall++;
            chk("t4_haddr_hold", HADDR, 32'h8);
            chk("t4_htrans_hold", 32'(HTRANS), 32'h2);
            @(negedge HCLK);
        end
        chk("t4_stall_cycles", 32'(stall), 32'd3);
        @(negedge HCLK);
        chk("t4_rsp_after_ready", 32'(rsp_valid), 32'd1);
        repeat (3) @(negedge HCLK);

        // 5: twenty wait states trip the sticky timeout at the 16th stalled edge
        wait_cfg = 20;
        issue(1'b0, 3'b010, 32'h8, 32'h0);
        idle();
        @(negedge HCLK);
        wait_cfg = 0;
        repeat (15) @(negedge HCLK);
        chk("t5_no_timeout_15", 32'(bus_timeout), 32'd0);
        @(negedge HCLK);
        chk("t5_timeout_16", 32'(bus_timeout), 32'd1);
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge HCLK);
            seen = rsp_valid;
        end
        chk("t5_completed", 32'(seen), 32'd1);
        @(negedge HCLK);
        chk("t5_timeout_sticky", 32'(bus_timeout), 32'd1);
        repeat (2) @(negedge HCLK);

        // 6: reset during a stalled read data phase
        wait_cfg = 5;
        issue(1'b0, 3'b010, 32'h4, 32'h0);
        issue(1'b0, 3'b010, 32'h0, 32'h0);
        @(negedge HCLK);
        cmd_valid = 1'b0;
        wait_cfg = 0;
        chk("t6_pre_htrans", 32'(HTRANS), 32'h2);
        #1 HRESETn = 1'b0;
        #1;
        chk("t6_htrans", 32'(HTRANS), 32'd0);
        chk("t6_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("t6_timeout_clr", 32'(bus_timeout), 32'd0);
        chk("t6_haddr", HADDR, 32'd0);
        sb.delete();
        @(negedge HCLK);
        HRESETn = 1'b1;
        repeat (6) @(negedge HCLK);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=no finish expected=finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
